// File: rtl/reg_wb_arbiter_if.sv
// rtl/reg_wb_arbiter_if.sv - write-back port bundle between the requesters, decode, register file and reg_wb_arbiter
//
// Purpose: groups every handshake and bus signal of the write-back arbiter.
// Signals:
//   alu_req/alu_reg/alu_data, alu_gnt : ALU result write-back request and grant
//   mem_req/mem_reg/mem_data, mem_gnt : load write-back request and grant
//   sb_set/sb_reg                     : issue stage marks a destination register pending
//   read_reg1/read_reg2, stall        : decode source operands and read-hazard stall
//   busy                              : pending-write scoreboard, bit i = register i
//   write_reg/write_data/wr_en        : register file write port
//   wb_err                            : sticky protocol error flag
// Modports: master = requesters/decode/register file side, slave = arbiter.

interface reg_wb_arbiter_if #(
    parameter int NREG = 8,
    parameter int DW   = 16
);
    logic            alu_req;
    logic [2:0]      alu_reg;
    logic [DW-1:0]   alu_data;
    logic            alu_gnt;
    logic            mem_req;
    logic [2:0]      mem_reg;
    logic [DW-1:0]   mem_data;
    logic            mem_gnt;
    logic            sb_set;
    logic [2:0]      sb_reg;
    logic [2:0]      read_reg1;
    logic [2:0]      read_reg2;
    logic            stall;
    logic [NREG-1:0] busy;
    logic [2:0]      write_reg;
    logic [DW-1:0]   write_data;
    logic            wr_en;
    logic            wb_err;

    modport master (
        output alu_req, alu_reg, alu_data, mem_req, mem_reg, mem_data,
               sb_set, sb_reg, read_reg1, read_reg2,
        input  alu_gnt, mem_gnt, stall, busy, write_reg, write_data, wr_en, wb_err
    );

    modport slave (
        input  alu_req, alu_reg, alu_data, mem_req, mem_reg, mem_data,
               sb_set, sb_reg, read_reg1, read_reg2,
        output alu_gnt, mem_gnt, stall, busy, write_reg, write_data, wr_en, wb_err
    );
endinterface

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - register file write-back arbiter with pending-write scoreboard
//
// Purpose: shares the single register file write port between the ALU result
// path and the memory-load path, tracks pending writes per register and
// raises a read-hazard stall for decode.
// Ports:
//   i_clk : clock, all state on the rising edge
//   i_rst : synchronous reset, active-high
//   bus   : reg_wb_arbiter_if.slave (requests, grants, scoreboard, stall, write port, wb_err)
// Parameters: NREG (scoreboard bits), DW (data width), RR_EN (1 = round-robin,
//   0 = ALU fixed priority), WRITE_R0 (0 = writes to r0 granted but suppressed).
// Optional feature: define WB_CHECK_EN to build the sticky wb_err protocol
//   checker; otherwise wb_err is tied to 0.

module reg_wb_arbiter #(
    parameter int NREG     = 8,
    parameter int DW       = 16,
    parameter int RR_EN    = 1,
    parameter int WRITE_R0 = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    reg_wb_arbiter_if.slave  bus
);
    logic            r_rr_mem_first;   // 1 = load path wins the next contention
    logic            r_wr_en;
    logic [2:0]      r_write_reg;
    logic [DW-1:0]   r_write_data;
    logic [NREG-1:0] r_busy;

    logic            w_alu_gnt;
    logic            w_mem_gnt;
    logic            w_xfer;
    logic [2:0]      w_reg;
    logic [DW-1:0]   w_data;
    logic            w_reg_ok;
    logic            w_set_ok;
    logic [NREG-1:0] w_set_vec;
    logic [NREG-1:0] w_clr_vec;

    // ALU loses only when both request, round-robin is on and the pointer favours the load path.
    assign w_alu_gnt = !i_rst && bus.alu_req &&
                       (!bus.mem_req || (RR_EN == 0) || !r_rr_mem_first);
    assign w_mem_gnt = !i_rst && bus.mem_req && !w_alu_gnt;
    assign w_xfer    = w_alu_gnt || w_mem_gnt;
    assign w_reg     = w_alu_gnt ? bus.alu_reg  : bus.mem_reg;
    assign w_data    = w_alu_gnt ? bus.alu_data : bus.mem_data;

    // r0 writes and r0 scoreboard marks are dropped unless r0 is writable.
    assign w_reg_ok  = (WRITE_R0 != 0) || (w_reg != 3'd0);
    assign w_set_ok  = bus.sb_set && ((WRITE_R0 != 0) || (bus.sb_reg != 3'd0));
    assign w_set_vec = w_set_ok ? (NREG'(1) << bus.sb_reg) : '0;
    // The clear follows the registered write, i.e. after the falling-edge commit.
    assign w_clr_vec = r_wr_en ? (NREG'(1) << r_write_reg) : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_mem_first <= 1'b0;
            r_wr_en        <= 1'b0;
            r_write_reg    <= 3'd0;
            r_write_data   <= '0;
            r_busy         <= '0;
        end else begin
            r_wr_en <= w_xfer && w_reg_ok;
            if (w_xfer) begin
                r_write_reg    <= w_reg;
                r_write_data   <= w_data;
                r_rr_mem_first <= w_alu_gnt;
            end
            // Set after clear so a same-edge set wins.
            r_busy <= (r_busy & ~w_clr_vec) | w_set_vec;
        end
    end

`ifdef WB_CHECK_EN
    logic r_wb_err;
    logic w_err_unmarked;
    logic w_err_double;

    assign w_err_unmarked = w_xfer && (w_reg != 3'd0) && !r_busy[w_reg];
    assign w_err_double   = w_set_ok && r_busy[bus.sb_reg] && !w_clr_vec[bus.sb_reg];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wb_err <= 1'b0;
        end else if (w_err_unmarked || w_err_double) begin
            r_wb_err <= 1'b1;
        end
    end

    assign bus.wb_err = r_wb_err;
`else
    assign bus.wb_err = 1'b0;
`endif

    assign bus.alu_gnt    = w_alu_gnt;
    assign bus.mem_gnt    = w_mem_gnt;
    assign bus.wr_en      = r_wr_en;
    assign bus.write_reg  = r_write_reg;
    assign bus.write_data = r_write_data;
    assign bus.busy       = r_busy;
    assign bus.stall      = r_busy[bus.read_reg1] | r_busy[bus.read_reg2];
endmodule
